// File: rtl/mem_pair_pkg.sv
// Shared constants and types for the paired-array stream loader.
package mem_pair_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned DEPTH_DEF  = 8;

   typedef enum logic [1:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StDone
   } state_t;

   typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/loader_beat_counter.sv
// Beat index for one array pass; wrap flags the accepted beat that hits DEPTH-1.
module loader_beat_counter
   import mem_pair_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     inc,
   input  logic                     clr,
   output logic [$clog2(DEPTH)-1:0] idx,
   output logic                     wrap
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   logic [IdxW-1:0] idx_q, idx_d;

   assign wrap = inc && (idx_q == IdxW'(DEPTH - 1));
   assign idx  = idx_q;

   // clr wins over inc so a restart always begins at entry 0
   always_comb begin
      idx_d = idx_q;
      if (clr) begin
         idx_d = '0;
      end else if (inc) begin
         idx_d = wrap ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/mem_pair_loader.sv
// Streams 2*DEPTH words into two register arrays (mem_a then mem_b).
// Optional MEM_PAIR_LOADER_CLEAR_ON_START_EN zeroes both arrays when a load starts.
module mem_pair_loader
   import mem_pair_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic [DATA_W-1:0] mem_a [0:DEPTH-1],
   output logic [DATA_W-1:0] mem_b [0:DEPTH-1],
   output logic              bank_valid,
   output logic              busy,
   output logic              err_short
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   state_t            state_q, state_d;
   logic              s_ready_q, s_ready_d;
   logic              busy_q, busy_d;
   logic              bank_valid_q, bank_valid_d;
   logic              err_short_q, err_short_d;
   logic [DATA_W-1:0] mem_a_q [0:DEPTH-1];
   logic [DATA_W-1:0] mem_a_d [0:DEPTH-1];
   logic [DATA_W-1:0] mem_b_q [0:DEPTH-1];
   logic [DATA_W-1:0] mem_b_d [0:DEPTH-1];

   logic            accept;
   logic            cnt_clr;
   logic            wrap;
   logic [IdxW-1:0] idx;

   assign accept = s_valid && s_ready_q;

   loader_beat_counter #(
      .DEPTH (DEPTH)
   ) u_beat_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (accept),
      .clr   (cnt_clr),
      .idx   (idx),
      .wrap  (wrap)
   );

   always_comb begin
      state_d      = state_q;
      bank_valid_d = bank_valid_q;
      err_short_d  = err_short_q;
      mem_a_d      = mem_a_q;
      mem_b_d      = mem_b_q;
      cnt_clr      = 1'b0;

      if (start) begin
         state_d      = StLoadA;
         bank_valid_d = 1'b0;
         err_short_d  = 1'b0;
         cnt_clr      = 1'b1;
`ifdef MEM_PAIR_LOADER_CLEAR_ON_START_EN
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_a_d[i] = '0;
            mem_b_d[i] = '0;
         end
`endif
      end

      // A beat accepted alongside a restart is still written
      if (accept) begin
         if (state_q == StLoadA) begin
            mem_a_d[idx] = s_data;
         end else begin
            mem_b_d[idx] = s_data;
         end
      end

      if (!start && accept) begin
         if (s_last && !(state_q == StLoadB && wrap)) begin
            state_d     = StIdle;
            err_short_d = 1'b1;
            cnt_clr     = 1'b1;
         end else if (wrap) begin
            if (state_q == StLoadA) begin
               state_d = StLoadB;
            end else begin
               state_d      = StDone;
               bank_valid_d = 1'b1;
            end
         end
      end

      s_ready_d = (state_d == StLoadA) || (state_d == StLoadB);
      busy_d    = s_ready_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         s_ready_q    <= 1'b0;
         busy_q       <= 1'b0;
         bank_valid_q <= 1'b0;
         err_short_q  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_a_q[i] <= '0;
            mem_b_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         s_ready_q    <= s_ready_d;
         busy_q       <= busy_d;
         bank_valid_q <= bank_valid_d;
         err_short_q  <= err_short_d;
         mem_a_q      <= mem_a_d;
         mem_b_q      <= mem_b_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign busy       = busy_q;
   assign bank_valid = bank_valid_q;
   assign err_short  = err_short_q;
   assign mem_a      = mem_a_q;
   assign mem_b      = mem_b_q;

endmodule

// File: tb/tb_mem_pair_loader.sv
// Scoreboard bench for mem_pair_loader: each load ending is queued by the stimulus
// and checked by a monitor when busy falls.
module tb_mem_pair_loader;
   import mem_pair_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned DP = 8;

   typedef struct packed {
      logic             bv;
      logic             err;
      logic [DP*DW-1:0] a;
      logic [DP*DW-1:0] b;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, s_valid, s_ready, s_last;
   word_t         s_data;
   logic [DW-1:0] mem_a [0:DP-1];
   logic [DW-1:0] mem_b [0:DP-1];
   logic          bank_valid, busy, err_short;

   always #5 clk = ~clk;

   mem_pair_loader #(
      .DATA_W (DW),
      .DEPTH  (DP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .mem_a      (mem_a),
      .mem_b      (mem_b),
      .bank_valid (bank_valid),
      .busy       (busy),
      .err_short  (err_short)
   );

   exp_t          q[$];
   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] ea [0:DP-1];
   logic [DW-1:0] eb [0:DP-1];
   int            ph = 0;  // 0 idle, 1 load A, 2 load B, 3 done
   int            k  = 0;
   int            cyc = 0;
   int            start_cyc = 0;
   int            rise_cyc  = -1;
   logic          bv_prev   = 1'b0;
   logic          busy_prev = 1'b0;
   exp_t          me;

   function automatic logic [DP*DW-1:0] pack(input logic [DW-1:0] m [0:DP-1]);
      logic [DP*DW-1:0] r;
      for (int i = 0; i < DP; i++) r[i*DW +: DW] = m[i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [DP*DW-1:0] act,
                      input logic [DP*DW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic bv, input logic err);
      exp_t e;
      e.bv  = bv;
      e.err = err;
      e.a   = pack(ea);
      e.b   = pack(eb);
      q.push_back(e);
   endtask

   task automatic zero_model();
      for (int i = 0; i < DP; i++) begin
         ea[i] = '0;
         eb[i] = '0;
      end
      ph = 0;
      k  = 0;
   endtask

   // One clock of stimulus; model state afterwards reflects the DUT after the next edge
   task automatic cycle(input logic st, input logic v, input word_t d, input logic l);
      logic acc;
      @(negedge clk);
      cyc++;
      if (bank_valid && !bv_prev && rise_cyc < 0) rise_cyc = cyc;
      bv_prev = bank_valid;
      chk("s_ready", s_ready, (ph == 1 || ph == 2));
      chk("busy", busy, (ph == 1 || ph == 2));
      acc = v && s_ready;
`ifdef MEM_PAIR_LOADER_CLEAR_ON_START_EN
      if (st) begin
         for (int i = 0; i < DP; i++) begin
            ea[i] = '0;
            eb[i] = '0;
         end
      end
`endif
      if (acc) begin
         if (ph == 1) ea[k] = d;
         else eb[k] = d;
      end
      if (st) begin
         ph = 1;
         k  = 0;
         start_cyc = cyc;
         rise_cyc  = -1;
      end else if (acc) begin
         if (l && !(ph == 2 && k == DP - 1)) begin
            ph = 0;
            k  = 0;
            push_exp(1'b0, 1'b1);
         end else if (k == DP - 1) begin
            k = 0;
            if (ph == 1) begin
               ph = 2;
            end else begin
               ph = 3;
               push_exp(1'b1, 1'b0);
            end
         end else begin
            k++;
         end
      end
      start   = st;
      s_valid = v;
      s_data  = d;
      s_last  = l;
   endtask

   task automatic full_load(input word_t base_a, input word_t base_b, input logic gaps);
      cycle(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 2 * DP; i++) begin
         cycle(1'b0, 1'b1, (i < DP) ? base_a * word_t'(i + 1) : base_b + word_t'(i - DP),
               (i == 2 * DP - 1));
         if (gaps) cycle(1'b0, 1'b0, 16'hFFFF, 1'b1);
      end
      cycle(1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (busy_prev && !busy) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_end: got busy fall want none queued");
         end else begin
            me = q.pop_front();
            chk("end_bank_valid", bank_valid, me.bv);
            chk("end_err_short", err_short, me.err);
            chk("end_mem_a", pack(mem_a), me.a);
            chk("end_mem_b", pack(mem_b), me.b);
         end
      end
      busy_prev = busy;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      s_last = 1'b0;
      zero_model();
      repeat (2) @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_bank_valid", bank_valid, 0);
      chk("rst_err_short", err_short, 0);
      chk("rst_mem_a", pack(mem_a), 0);
      chk("rst_mem_b", pack(mem_b), 0);
      rst_n = 1'b1;

      // s_valid in IDLE is ignored
      cycle(1'b0, 1'b1, 16'hDEAD, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      chk("idle_ignore_a", pack(mem_a), 0);

      // Normal load: A = 1111..8888, B = 0001..0008
      full_load(16'h1111, 16'h0001, 1'b0);
      chk("latency", rise_cyc - start_cyc, 17);
      chk("a0", mem_a[0], 16'h1111);
      chk("b7", mem_b[7], 16'h0008);

      // Same load with an idle cycle after every beat
      full_load(16'h1111, 16'h0001, 1'b1);

      // Early s_last on beat 5
      cycle(1'b1, 1'b0, '0, 1'b0);
      for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 16'hA000 + word_t'(i), (i == 5));
      cycle(1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      chk("short_a4", mem_a[4], 16'hA005);
      chk("short_a5", mem_a[5], 16'h6666);
      chk("short_err", err_short, 1);
      chk("short_bv", bank_valid, 0);

      // Restart on beat 10: that beat lands in mem_b[1]
      cycle(1'b1, 1'b0, '0, 1'b0);
      for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b1, 16'hB000 + word_t'(i), 1'b0);
      cycle(1'b1, 1'b1, 16'hB00A, 1'b0);
      cycle(1'b0, 1'b1, 16'hC001, 1'b0);
      chk("restart_b1", mem_b[1], 16'hB00A);
`ifndef MEM_PAIR_LOADER_CLEAR_ON_START_EN
      chk("restart_a0_old", mem_a[0], 16'hB001);
`endif
      cycle(1'b0, 1'b1, 16'hC002, 1'b0);
      chk("restart_a0_new", mem_a[0], 16'hC001);
      for (int i = 3; i <= 8; i++) cycle(1'b0, 1'b1, 16'hC000 + word_t'(i), 1'b0);
      for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 16'hD000 + word_t'(i), (i == 8));
      cycle(1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      chk("restart_done_bv", bank_valid, 1);

      // Reset pulse during LOAD_B
      cycle(1'b1, 1'b0, '0, 1'b0);
      for (int i = 1; i <= 10; i++) cycle(1'b0, 1'b1, 16'hE000 + word_t'(i), 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      zero_model();
      push_exp(1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_s_ready", s_ready, 0);
      chk("async_busy", busy, 0);
      chk("async_mem_a", pack(mem_a), 0);
      chk("async_mem_b", pack(mem_b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 16'h5555, 1'b0);
         chk("post_rst_bv", bank_valid, 0);
      end

`ifdef MEM_PAIR_LOADER_CLEAR_ON_START_EN
      full_load(16'h1111, 16'h0001, 1'b0);
      cycle(1'b1, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b1, 16'h0001, 1'b1);
      chk("clear_a", pack(mem_a), 0);
      chk("clear_b", pack(mem_b), 0);
      cycle(1'b0, 1'b0, '0, 1'b0);
`endif

      repeat (3) cycle(1'b0, 1'b0, '0, 1'b0);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
